i2c_slave: RTL and testbench
============================

Name: i2c_slave

Overview:
- I2C target (slave) that answers the team's I2C master on the same SCL/SDA pair.
- Recognises START, repeated START and STOP.
- Matches a fixed 7-bit address and ACKs it.
- Receives write bytes and hands them to the user side; sources read bytes from the user side and checks the master ACK/NACK.
- Sits beside the sensor/register logic on the bus. SCL is input only: no clock stretching. SDA is open-drain.

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit bus address this block responds to.
- SYNC_STAGES, 2, synchroniser flops on SCL and SDA inputs (minimum 2).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- scl  input  1  I2C clock from master.
- sda  inout  1  I2C data. Driven 0 when sda_drv_low=1, otherwise 1'bz. Never driven 1.
- tx_data  input  8  byte to return on a read. Sampled at the SCL fall that starts its first bit.
- tx_req  output  1  1-cycle pulse: next read byte needed. tx_data must be valid before the next synced SCL fall.
- rx_data  output  8  last byte written by master.
- rx_done  output  1  1-cycle pulse: rx_data updated.
- rw  output  1  R/W bit of the current matched transfer (1 = master read).
- addr_hit  output  1  1-cycle pulse: address matched and ACK slot begins.
- busy  output  1  1 while state != IDLE.

Behaviour:
- Reset (reset=0, async)
  - State IDLE, SDA released (z) immediately, even mid-ACK or mid-data.
  - rx_data=0, rw=0; tx_req, rx_done, addr_hit, busy = 0.
  - Shift and bit counters = 0; synchronisers preset to 1.
- Input conditioning
  - scl/sda pass through SYNC_STAGES flops, then one history flop.
  - scl_rise/scl_fall, START (sda 1->0 while scl=1) and STOP (sda 0->1 while scl=1) are single-cycle strobes.
  - All decisions use these synced strobes, so latency is SYNC_STAGES+1 cycles after the pin edge.
- Bus events override everything
  - START in any state: go to ADDR, bit_cnt=0, release SDA. Repeated START is identical.
  - STOP in any state: go to IDLE, release SDA.
  - Any SDA change while SCL high is treated as START/STOP; there is no glitch filter.
- States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
- IDLE: SDA released; wait for START.
- ADDR
  - On each scl_rise shift sda into shift[0], MSB first; bit_cnt+1.
  - After the 8th rise, at the next scl_fall:
    - shift[7:1]==SLAVE_ADDR: latch rw=shift[0], drive SDA low, pulse addr_hit, pulse tx_req if rw=1, go ADDR_ACK.
    - Otherwise: go WAIT_STOP with SDA released.
- ADDR_ACK
  - Hold SDA low through the 9th SCL high.
  - At the following scl_fall, bit_cnt=0:
    - rw=0: release SDA, go WR_DATA.
    - rw=1: load shift=tx_data, drive SDA low if shift[7]=0 else release, go RD_DATA.
- WR_DATA
  - SDA released; shift in on each scl_rise.
  - After the 8th rise, at the next scl_fall: rx_data<=shift, pulse rx_done, drive SDA low, go WR_ACK.
  - Every written byte is ACKed.
- WR_ACK: hold SDA low; at next scl_fall release SDA, bit_cnt=0, go WR_DATA.
- RD_DATA
  - SDA reflects shift[7] and changes only on scl_fall; shift left on each scl_fall after a bit has been presented.
  - After the 8th bit's scl_fall: release SDA, go RD_ACK.
- RD_ACK
  - At the 9th scl_rise sample sda.
  - sda=0 (ACK): pulse tx_req at that rise; at next scl_fall load tx_data, present bit7, go RD_DATA.
  - sda=1 (NACK): go WAIT_STOP (SDA released).
- WAIT_STOP: SDA released; leave only on STOP (to IDLE) or START (to ADDR).
- Simultaneous events
  - START/STOP takes priority over a same-cycle scl edge.
  - Pulses never overlap within one cycle except addr_hit+tx_req.
- Master timing: SCL half period is 500 clk, data settles 250 clk into SCL low. Synchroniser latency (<= 4 clk) is negligible against this; SDA must be valid at least 200 clk before scl_rise.

Test Plan:
- Write: START, 0xA0, 0x3C, STOP from master → ACK sampled 0 on both bytes; addr_hit=1 pulse; rw=0; rx_done exactly 1 pulse; rx_data=0x3C; busy back to 0 after STOP.
- Read 2 bytes: START, 0xA1, tx_data=0x5A then 0xC3 on tx_req, master ACK then NACK, STOP → master reads 0x5A, 0xC3; tx_req 2 pulses; SDA released after NACK.
- Wrong address: START, 0xA4 (addr 0x52), data, STOP → ACK sampled 1 (SDA z throughout), no addr_hit/rx_done, state WAIT_STOP until STOP.
- Repeated START: START, 0xA0, 0x01, Sr, 0xA1, read 1 byte NACK, STOP → rx_data=0x01, rw switches to 1, read byte = tx_data, busy ends at STOP.
- Reset mid-ACK: assert reset=0 while slave holds SDA low in ADDR_ACK → SDA z same cycle (async); all outputs 0; after release, no response until a new START.
- Early STOP: STOP after 4 data bits of a write → IDLE, no rx_done, rx_data unchanged.

Source files
------------

// File: rtl/i2c_slave.sv
// I2C target: fixed 7-bit address, write bytes to the user side, read bytes
// from the user side, open-drain SDA, SCL input only (no clock stretching).
module i2c_slave #(
    parameter logic [6:0]  SLAVE_ADDR  = 7'h50,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    inout  wire        sda,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       rw,
    output logic       addr_hit,
    output logic       busy
);

    localparam int unsigned STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int unsigned CNT_W  = 4;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(8);
    localparam logic [CNT_W-1:0] LAST_RD  = CNT_W'(7);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        WAIT_STOP
    } state_t;

    state_t             state;
    logic [STAGES-1:0]  scl_sync;
    logic [STAGES-1:0]  sda_sync;
    logic               scl_d;
    logic               sda_d;
    logic [7:0]         shift;
    logic [CNT_W-1:0]   bit_cnt;
    logic               sda_drv_low;

    logic scl_s;
    logic sda_s;
    logic scl_rise;
    logic scl_fall;
    logic start_evt;
    logic stop_evt;

    // Open-drain pad: only ever pull low
    assign sda = sda_drv_low ? 1'b0 : 1'bz;

    assign scl_s     = scl_sync[STAGES-1];
    assign sda_s     = sda_sync[STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_evt = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_evt  = scl_s & scl_d & ~sda_d & sda_s;

    // Synchronise the bus pins and keep one history flop for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[STAGES-2:0], scl};
            sda_sync <= {sda_sync[STAGES-2:0], sda};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    // Protocol FSM; bus START/STOP override any same-cycle SCL edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            shift       <= '0;
            bit_cnt     <= '0;
            sda_drv_low <= 1'b0;
            rx_data     <= '0;
            rx_done     <= 1'b0;
            rw          <= 1'b0;
            addr_hit    <= 1'b0;
            tx_req      <= 1'b0;
            busy        <= 1'b0;
        end else begin
            rx_done  <= 1'b0;
            addr_hit <= 1'b0;
            tx_req   <= 1'b0;
            if (start_evt) begin
                state       <= ADDR;
                bit_cnt     <= '0;
                sda_drv_low <= 1'b0;
                busy        <= 1'b1;
            end else if (stop_evt) begin
                state       <= IDLE;
                sda_drv_low <= 1'b0;
                busy        <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        sda_drv_low <= 1'b0;
                    end
                    ADDR: begin
                        if (scl_rise && bit_cnt != LAST_BIT) begin
                            shift   <= {shift[6:0], sda_s};
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end else if (scl_fall && bit_cnt == LAST_BIT) begin
                            if (shift[7:1] == SLAVE_ADDR) begin
                                rw          <= shift[0];
                                sda_drv_low <= 1'b1;
                                addr_hit    <= 1'b1;
                                tx_req      <= shift[0];
                                state       <= ADDR_ACK;
                            end else begin
                                sda_drv_low <= 1'b0;
                                state       <= WAIT_STOP;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= '0;
                            if (!rw) begin
                                sda_drv_low <= 1'b0;
                                state       <= WR_DATA;
                            end else begin
                                shift       <= tx_data;
                                sda_drv_low <= ~tx_data[7];
                                state       <= RD_DATA;
                            end
                        end
                    end
                    WR_DATA: begin
                        if (scl_rise && bit_cnt != LAST_BIT) begin
                            shift   <= {shift[6:0], sda_s};
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end else if (scl_fall && bit_cnt == LAST_BIT) begin
                            rx_data     <= shift;
                            rx_done     <= 1'b1;
                            sda_drv_low <= 1'b1;
                            state       <= WR_ACK;
                        end
                    end
                    WR_ACK: begin
                        if (scl_fall) begin
                            sda_drv_low <= 1'b0;
                            bit_cnt     <= '0;
                            state       <= WR_DATA;
                        end
                    end
                    RD_DATA: begin
                        if (scl_fall) begin
                            if (bit_cnt == LAST_RD) begin
                                sda_drv_low <= 1'b0;
                                bit_cnt     <= '0;
                                state       <= RD_ACK;
                            end else begin
                                bit_cnt     <= bit_cnt + CNT_W'(1);
                                shift       <= {shift[6:0], 1'b0};
                                sda_drv_low <= ~shift[6];
                            end
                        end
                    end
                    RD_ACK: begin
                        // A fall here is only reachable after an ACKed rise
                        if (scl_rise) begin
                            if (sda_s) begin
                                state <= WAIT_STOP;
                            end else begin
                                tx_req <= 1'b1;
                            end
                        end else if (scl_fall) begin
                            shift       <= tx_data;
                            sda_drv_low <= ~tx_data[7];
                            bit_cnt     <= '0;
                            state       <= RD_DATA;
                        end
                    end
                    WAIT_STOP: begin
                        sda_drv_low <= 1'b0;
                    end
                    default: begin
                        sda_drv_low <= 1'b0;
                        state       <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-banged I2C master, scoreboard queues for
// written bytes and read bytes.
module tb_i2c_slave;

    localparam int unsigned HALF = 40;
    localparam int unsigned QTR  = HALF / 2;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       scl     = 1'b1;
    logic       m_low   = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_req;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rw;
    logic       addr_hit;
    logic       busy;
    wire        sda;

    assign sda = m_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_slave #(
        .SLAVE_ADDR (7'h50),
        .SYNC_STAGES(2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .scl     (scl),
        .sda     (sda),
        .tx_data (tx_data),
        .tx_req  (tx_req),
        .rx_data (rx_data),
        .rx_done (rx_done),
        .rw      (rw),
        .addr_hit(addr_hit),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int n_hit    = 0;
    int n_rx     = 0;
    int n_txreq  = 0;

    logic [7:0] exp_rx[$];
    logic [7:0] exp_rd[$];
    logic [7:0] tx_src[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Pulse counters, read-byte supply and written-byte scoreboard
    always @(negedge clk) begin
        if (addr_hit) n_hit++;
        if (tx_req) begin
            n_txreq++;
            if (tx_src.size() != 0) begin
                tx_data = tx_src.pop_front();
                exp_rd.push_back(tx_data);
            end
        end
        if (rx_done) begin
            n_rx++;
            if (exp_rx.size() == 0) check("rx_unexpected", 32'(rx_data), 32'hFFFF_FFFF);
            else                    check("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
        end
    end

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_xfer(input logic b, output logic r);
        tick(QTR);
        m_low = ~b;
        tick(QTR);
        scl = 1'b1;
        tick(QTR);
        r = sda;
        tick(QTR);
        scl = 1'b0;
    endtask

    task automatic start_cond();
        if (scl == 1'b0) begin
            tick(QTR);
            m_low = 1'b0;
            tick(QTR);
            scl = 1'b1;
        end
        tick(QTR);
        m_low = 1'b1;
        tick(QTR);
        scl = 1'b0;
    endtask

    task automatic stop_cond();
        tick(QTR);
        m_low = 1'b1;
        tick(QTR);
        scl = 1'b1;
        tick(QTR);
        m_low = 1'b0;
        tick(QTR);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], r);
        bit_xfer(1'b1, ack);
    endtask

    task automatic read_byte(input logic master_ack);
        logic       r;
        logic [7:0] d;
        d = '0;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, r);
            d[i] = r;
        end
        if (exp_rd.size() == 0) check("rd_unexpected", 32'(d), 32'hFFFF_FFFF);
        else                    check("rd_data", 32'(d), 32'(exp_rd.pop_front()));
        bit_xfer(~master_ack, r);
    endtask

    initial begin
        logic       a;
        logic [7:0] b;
        int         h0;
        int         r0;

        // Reset state
        #1 reset = 1'b0;
        tick(3);
        check("rst_busy", 32'(busy), 0);
        check("rst_rx_data", 32'(rx_data), 0);
        check("rst_rw", 32'(rw), 0);
        check("rst_sda", 32'(sda), 1);
        reset = 1'b1;
        tick(5);

        // Write one byte
        start_cond();
        write_byte(8'hA0, a);
        check("wr_addr_ack", 32'(a), 0);
        check("wr_rw", 32'(rw), 0);
        exp_rx.push_back(8'h3C);
        write_byte(8'h3C, a);
        check("wr_data_ack", 32'(a), 0);
        check("wr_busy", 32'(busy), 1);
        stop_cond();
        tick(4);
        check("wr_busy_end", 32'(busy), 0);
        check("wr_hits", 32'(n_hit), 1);
        check("wr_rx_cnt", 32'(n_rx), 1);
        check("wr_rx_data", 32'(rx_data), 32'h3C);

        // Read two bytes, ACK then NACK
        tx_src.push_back(8'h5A);
        tx_src.push_back(8'hC3);
        start_cond();
        write_byte(8'hA1, a);
        check("rd_addr_ack", 32'(a), 0);
        check("rd_rw", 32'(rw), 1);
        read_byte(1'b1);
        read_byte(1'b0);
        tick(4);
        check("rd_nack_release", 32'(sda), 1);
        check("rd_wait_busy", 32'(busy), 1);
        stop_cond();
        tick(4);
        check("rd_busy_end", 32'(busy), 0);
        check("rd_txreq_cnt", 32'(n_txreq), 2);
        check("rd_hits", 32'(n_hit), 2);

        // Wrong address
        start_cond();
        write_byte(8'hA4, a);
        check("na_addr_nack", 32'(a), 1);
        check("na_busy", 32'(busy), 1);
        write_byte(8'h55, a);
        check("na_data_nack", 32'(a), 1);
        stop_cond();
        tick(4);
        check("na_hits", 32'(n_hit), 2);
        check("na_rx_cnt", 32'(n_rx), 1);
        check("na_busy_end", 32'(busy), 0);

        // Write then repeated START into a one-byte read
        exp_rx.push_back(8'h01);
        tx_src.push_back(8'h9E);
        start_cond();
        write_byte(8'hA0, a);
        check("rs_wr_ack", 32'(a), 0);
        write_byte(8'h01, a);
        check("rs_data_ack", 32'(a), 0);
        check("rs_rw_wr", 32'(rw), 0);
        start_cond();
        write_byte(8'hA1, a);
        check("rs_rd_ack", 32'(a), 0);
        check("rs_rw_rd", 32'(rw), 1);
        read_byte(1'b0);
        stop_cond();
        tick(4);
        check("rs_busy_end", 32'(busy), 0);
        check("rs_rx_data", 32'(rx_data), 32'h01);
        check("rs_hits", 32'(n_hit), 4);
        check("rs_txreq_cnt", 32'(n_txreq), 3);

        // Reset while the slave holds the address ACK
        start_cond();
        b = 8'hA0;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], a);
        m_low = 1'b0;
        tick(6);
        check("mr_ack_hold", 32'(sda), 0);
        reset = 1'b0;
        #1;
        check("mr_sda_release", 32'(sda), 1);
        check("mr_busy", 32'(busy), 0);
        check("mr_rx_data", 32'(rx_data), 0);
        check("mr_rw", 32'(rw), 0);
        check("mr_pulses", 32'({tx_req, rx_done, addr_hit}), 0);
        tick(1);
        reset = 1'b1;
        h0 = n_hit;
        r0 = n_rx;
        bit_xfer(1'b1, a);
        check("mr_ack_slot", 32'(a), 1);
        write_byte(8'h77, a);
        check("mr_data_nack", 32'(a), 1);
        check("mr_idle_busy", 32'(busy), 0);
        stop_cond();
        tick(4);
        check("mr_hits", 32'(n_hit), 32'(h0));
        check("mr_rx_cnt", 32'(n_rx), 32'(r0));

        // STOP after four data bits of a write
        exp_rx.push_back(8'h5E);
        start_cond();
        write_byte(8'hA0, a);
        check("es_addr_ack", 32'(a), 0);
        write_byte(8'h5E, a);
        check("es_data_ack", 32'(a), 0);
        bit_xfer(1'b1, a);
        bit_xfer(1'b0, a);
        bit_xfer(1'b1, a);
        bit_xfer(1'b0, a);
        stop_cond();
        tick(4);
        check("es_busy_end", 32'(busy), 0);
        check("es_rx_data", 32'(rx_data), 32'h5E);
        check("es_rx_cnt", 32'(n_rx), 32'(r0 + 1));

        // Scoreboards drained
        check("sb_rx_left", 32'(exp_rx.size()), 0);
        check("sb_rd_left", 32'(exp_rd.size()), 0);
        check("sb_tx_left", 32'(tx_src.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
